// File: rtl/huff_table_builder.sv
// huff_table_builder
//
// Builds a canonical Huffman code table from a buffer of per-symbol code
// lengths. The job runs in three passes:
//   CNT    - histogram the code lengths into bl_count[]
//   CODE   - one length per cycle, derive the first code of every length
//   ASSIGN - re-read the lengths and write one table entry per symbol,
//            post-incrementing the per-length code counter
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job request, honoured only in IDLE
//   sym_num, base_addr    job size (clamped to MAX_SYMS) and table offset
//   len_raddr, len_rdata  length buffer read port, 1-cycle read latency
//   tbl_wen, tbl_waddr    table write strobe and address (base + index)
//   tbl_code, tbl_len     right-aligned code and its length (0 = unused)
//   busy, done            job in progress / one-cycle completion pulse
//   err                   sticky job error, cleared by the next start
//
// Parameters: MAX_SYMS, MAX_LEN, ADDR_W, CODE_REV (1 = bit-reversed codes).
//
// Build option: define HUFF_TBL_CHECK_EN to build the length-range and
// oversubscription checks that drive err. Without it err is tied low.
//
// state  | meaning
// IDLE   | waiting for start
// CNT    | reading lengths 0..N-1 and counting codes per length (N+1 cycles)
// CODE   | computing next_code[1..MAX_LEN], one length per cycle
// ASSIGN | re-reading lengths and writing table entries (N+1 cycles)
// DONE   | completion pulse, back to IDLE
module huff_table_builder #(
  parameter int MAX_SYMS = 288,
  parameter int MAX_LEN  = 15,
  parameter int ADDR_W   = 9,
  parameter int CODE_REV = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  sym_num,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic [ADDR_W-1:0]  len_raddr,
  input  logic [4:0]         len_rdata,
  output logic               tbl_wen,
  output logic [ADDR_W-1:0]  tbl_waddr,
  output logic [MAX_LEN-1:0] tbl_code,
  output logic [3:0]         tbl_len,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] MAX_SYMS_A = ADDR_W'(MAX_SYMS);
  localparam logic [4:0]        MAX_LEN_5  = 5'(MAX_LEN);
  localparam logic [CW-1:0]     MAX_LEN_C  = CW'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, CNT, CODE, ASSIGN, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]      idx;
  logic [ADDR_W-1:0]  n_q;
  logic [ADDR_W-1:0]  base_q;
  // Entry 0 of both arrays is never written after reset, which supplies the
  // next_code[0] = bl_count[0] = 0 seed of the recurrence for free.
  logic [CW-1:0]      bl_count  [0:MAX_LEN];
  logic [MAX_LEN-1:0] next_code [0:MAX_LEN];

  logic               len_ok;
  logic [LW-1:0]      len_l;
  logic [LW-1:0]      step;
  logic [LW-1:0]      step_m1;
  logic               last_sym;
  logic [MAX_LEN-1:0] code_sel;
  logic [MAX_LEN-1:0] code_rev;
  logic [MAX_LEN-1:0] nc_sum;

  // Lengths above MAX_LEN are treated like unused symbols so they never
  // index outside the count/code arrays.
  assign len_ok   = (len_rdata != 5'd0) && (len_rdata <= MAX_LEN_5);
  assign len_l    = len_rdata[LW-1:0];
  assign step     = idx[LW-1:0];
  assign step_m1  = step - LW'(1);
  assign last_sym = (idx == {1'b0, n_q});
  assign code_sel = next_code[len_l];
  assign nc_sum   = next_code[step_m1] + MAX_LEN'(bl_count[step_m1]);

  always_comb begin
    code_rev = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_l)) code_rev[i] = code_sel[int'(len_l) - 1 - i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    len_raddr = '0;
    tbl_wen   = 1'b0;
    tbl_waddr = '0;
    tbl_code  = '0;
    tbl_len   = '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = CNT;
      CNT:     if (last_sym) state_nx = CODE;
      CODE:    if (idx == MAX_LEN_C) state_nx = ASSIGN;
      ASSIGN:  if (last_sym) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The extra (N+1)th cycle of CNT/ASSIGN only consumes read data.
    if ((state == CNT || state == ASSIGN) && !last_sym)
      len_raddr = idx[ADDR_W-1:0];
    // Symbol idx-1 was read in the previous cycle; write it now.
    if (state == ASSIGN && idx != '0) begin
      tbl_wen   = 1'b1;
      tbl_waddr = base_q + idx[ADDR_W-1:0] - ADDR_W'(1);
      if (len_ok) begin
        tbl_code = (CODE_REV != 0) ? code_rev : code_sel;
        tbl_len  = 4'(len_rdata);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      n_q    <= '0;
      base_q <= '0;
      for (int l = 0; l <= MAX_LEN; l++) begin
        bl_count[l]  <= '0;
        next_code[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            n_q    <= (sym_num > MAX_SYMS_A) ? MAX_SYMS_A : sym_num;
            base_q <= base_addr;
            for (int l = 1; l <= MAX_LEN; l++) bl_count[l] <= '0;
          end
        end
        CNT: begin
          if (idx != '0 && len_ok) bl_count[len_l] <= bl_count[len_l] + CW'(1);
          idx <= last_sym ? CW'(1) : idx + CW'(1);
        end
        CODE: begin
          next_code[step] <= {nc_sum[MAX_LEN-2:0], 1'b0};
          idx <= (idx == MAX_LEN_C) ? '0 : idx + CW'(1);
        end
        ASSIGN: begin
          if (idx != '0 && len_ok) next_code[len_l] <= code_sel + MAX_LEN'(1);
          idx <= idx + CW'(1);
        end
        default: idx <= '0;
      endcase
    end
  end

`ifdef HUFF_TBL_CHECK_EN
  // Kraft budget: left doubles per length and loses one slot per code.
  // Wide enough that it cannot wrap even after going negative.
  localparam int LFW = MAX_LEN + ADDR_W + 3;

  logic signed [LFW-1:0] left;
  logic signed [LFW-1:0] left_nx;
  logic                  err_q;

  assign left_nx = (left <<< 1) - $signed(LFW'(bl_count[step]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      left  <= '0;
    end else begin
      case (state)
        IDLE: if (start) err_q <= 1'b0;
        CNT: begin
          left <= LFW'(1);
          if (idx != '0 && len_rdata > MAX_LEN_5) err_q <= 1'b1;
        end
        CODE: begin
          left <= left_nx;
          if (left_nx[LFW-1]) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_huff_table_builder.sv
`timescale 1ns/1ps
module tb_huff_table_builder;

  localparam int ML = 15;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] sym_num = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] raddr, r_raddr, waddr, r_waddr;
  logic [4:0]    rdata, r_rdata;
  logic          wen, r_wen, busy, r_busy, done, r_done, err, r_err;
  logic [ML-1:0] code, r_code;
  logic [3:0]    tlen, r_tlen;

  logic [4:0] lenmem [0:511];

  int total = 0;
  int bad = 0;

  int ob_addr[$], ob_code[$], ob_len[$], ob_rcode[$];
  int done_cyc, done_cnt, busy_cnt, err_at_done, err_after, rev_diff, idle_bad;
  int exp_code[0:511], exp_rcode[0:511], exp_len[0:511];
  int exp_err;

  huff_table_builder #(.CODE_REV(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_num(sym_num),
    .base_addr(base_addr), .len_raddr(raddr), .len_rdata(rdata),
    .tbl_wen(wen), .tbl_waddr(waddr), .tbl_code(code), .tbl_len(tlen),
    .busy(busy), .done(done), .err(err)
  );

  huff_table_builder #(.CODE_REV(1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_num(sym_num),
    .base_addr(base_addr), .len_raddr(r_raddr), .len_rdata(r_rdata),
    .tbl_wen(r_wen), .tbl_waddr(r_waddr), .tbl_code(r_code), .tbl_len(r_tlen),
    .busy(r_busy), .done(r_done), .err(r_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata   <= lenmem[raddr];
    r_rdata <= lenmem[r_raddr];
  end

  // Canonical code assignment: walk lengths shortest first, symbols in index
  // order, handing out consecutive codes and doubling between lengths.
  task automatic model(input int n);
    int c;
    int mask;
    longint kraft;
    c = 0;
    mask = (1 << ML) - 1;
    kraft = 0;
    for (int i = 0; i < n; i++) begin
      exp_code[i]  = 0;
      exp_rcode[i] = 0;
      exp_len[i]   = int'(lenmem[i]);
    end
    for (int l = 1; l <= ML; l++) begin
      if (l > 1) c = (c << 1) & mask;
      for (int i = 0; i < n; i++) begin
        if (int'(lenmem[i]) == l) begin
          exp_code[i] = c;
          for (int b = 0; b < l; b++)
            exp_rcode[i] |= ((c >> (l - 1 - b)) & 1) << b;
          c = (c + 1) & mask;
          kraft += longint'(1) << (ML - l);
        end
      end
    end
`ifdef HUFF_TBL_CHECK_EN
    exp_err = (kraft > (longint'(1) << ML)) ? 1 : 0;
`else
    exp_err = 0;
`endif
  endtask

  // Drives one job and records what the DUTs did; judgments are left to
  // the calling test.
  task automatic run_job(input int n, input int base, input bit poke);
    ob_addr.delete(); ob_code.delete(); ob_len.delete(); ob_rcode.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; err_at_done = 0;
    err_after = 0; rev_diff = 0; idle_bad = 0;
    @(negedge clk);
    start = 1'b1; sym_num = AW'(n); base_addr = AW'(base);
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      start = poke && (c == 5);
      if (start) begin sym_num = AW'(3); base_addr = AW'(100); end
      if (wen) begin
        ob_addr.push_back(int'(waddr));
        ob_code.push_back(int'(code));
        ob_len.push_back(int'(tlen));
        ob_rcode.push_back(int'(r_code));
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = c; err_at_done = int'(err); end
      if (wen !== r_wen || waddr !== r_waddr || tlen !== r_tlen || busy !== r_busy ||
          done !== r_done || err !== r_err) rev_diff++;
      if (done_cyc >= 0 && c > done_cyc) begin
        err_after = int'(err);
        if (busy || wen || done || raddr != '0) idle_bad++;
      end
      if (done_cyc >= 0 && c == done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic load_example();
    int ex[10] = '{3, 3, 3, 4, 3, 2, 0, 4, 0, 3};
    for (int i = 0; i < 512; i++) lenmem[i] = 5'($urandom_range(0, 15));
    for (int i = 0; i < 10; i++) lenmem[i] = 5'(ex[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({wen, done, busy, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0000", {wen, done, busy, err});
    end
    total++;
    if (raddr !== '0 || waddr !== '0 || code !== '0 || tlen !== '0) begin
      bad++; $display("FAIL reset_data got raddr=%0d waddr=%0d code=%0d len=%0d exp all 0",
                      raddr, waddr, code, tlen);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wen, done, busy, err} !== 4'b0000 || raddr !== '0) begin
      bad++; $display("FAIL idle_after_reset got=%b raddr=%0d exp 0", {wen, done, busy, err}, raddr);
    end
  endtask

  task automatic test_example();
    int ex_code[10] = '{2, 3, 4, 14, 5, 0, 0, 15, 0, 6};
    int ex_len[10]  = '{3, 3, 3, 4, 3, 2, 0, 4, 0, 3};
    load_example();
    run_job(10, 0, 0);
    total++;
    if (ob_addr.size() != 10) begin
      bad++; $display("FAIL ex_writes got=%0d exp=10", ob_addr.size());
    end
    for (int i = 0; i < 10 && i < ob_addr.size(); i++) begin
      total++;
      if (ob_addr[i] != i || ob_code[i] != ex_code[i] || ob_len[i] != ex_len[i]) begin
        bad++; $display("FAIL ex_sym%0d got addr=%0d code=%0d len=%0d exp addr=%0d code=%0d len=%0d",
                        i, ob_addr[i], ob_code[i], ob_len[i], i, ex_code[i], ex_len[i]);
      end
    end
    if (ob_rcode.size() == 10) begin
      total++;
      if (ob_rcode[3] != 7 || ob_rcode[5] != 0 || ob_rcode[9] != 3) begin
        bad++; $display("FAIL ex_rev got=%0d,%0d,%0d exp=7,0,3", ob_rcode[3], ob_rcode[5], ob_rcode[9]);
      end
    end
    total++;
    if (done_cyc != 38 || done_cnt != 1) begin
      bad++; $display("FAIL ex_done got cyc=%0d cnt=%0d exp cyc=38 cnt=1", done_cyc, done_cnt);
    end
    total++;
    if (busy_cnt != 38) begin
      bad++; $display("FAIL ex_busy got=%0d exp=38", busy_cnt);
    end
    total++;
    if (err_at_done != 0 || rev_diff != 0 || idle_bad != 0) begin
      bad++; $display("FAIL ex_misc got err=%0d revdiff=%0d idlebad=%0d exp 0,0,0",
                      err_at_done, rev_diff, idle_bad);
    end
  endtask

  task automatic test_oversub();
    int e;
`ifdef HUFF_TBL_CHECK_EN
    e = 1;
`else
    e = 0;
`endif
    for (int i = 0; i < 3; i++) lenmem[i] = 5'd1;
    run_job(3, 7, 0);
    total++;
    if (ob_addr.size() != 3 || done_cyc != 24) begin
      bad++; $display("FAIL os_job got writes=%0d done=%0d exp writes=3 done=24", ob_addr.size(), done_cyc);
    end
    total++;
    if (err_at_done != e || err_after != e) begin
      bad++; $display("FAIL os_err got=%0d/%0d exp=%0d", err_at_done, err_after, e);
    end
  endtask

  task automatic test_empty();
    run_job(0, 5, 0);
    total++;
    if (ob_addr.size() != 0) begin
      bad++; $display("FAIL empty_writes got=%0d exp=0", ob_addr.size());
    end
    total++;
    if (done_cyc != 18 || done_cnt != 1) begin
      bad++; $display("FAIL empty_done got cyc=%0d cnt=%0d exp cyc=18 cnt=1", done_cyc, done_cnt);
    end
    total++;
    if (err_at_done != 0) begin
      bad++; $display("FAIL empty_err_clear got=%0d exp=0", err_at_done);
    end
  endtask

  task automatic test_wrap();
    int ea[4] = '{510, 511, 0, 1};
    for (int i = 0; i < 4; i++) lenmem[i] = 5'($urandom_range(1, 15));
    model(4);
    run_job(4, 510, 0);
    total++;
    if (ob_addr.size() != 4) begin
      bad++; $display("FAIL wrap_writes got=%0d exp=4", ob_addr.size());
    end
    for (int i = 0; i < 4 && i < ob_addr.size(); i++) begin
      total++;
      if (ob_addr[i] != ea[i] || ob_code[i] != exp_code[i]) begin
        bad++; $display("FAIL wrap_sym%0d got addr=%0d code=%0d exp addr=%0d code=%0d",
                        i, ob_addr[i], ob_code[i], ea[i], exp_code[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n, base;
      n = $urandom_range(1, 48);
      base = $urandom_range(0, 511);
      for (int i = 0; i < n; i++)
        lenmem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      model(n);
      run_job(n, base, 0);
      total++;
      if (ob_addr.size() != n || done_cyc != 2 * n + 18) begin
        bad++; $display("FAIL rnd%0d_job got writes=%0d done=%0d exp writes=%0d done=%0d",
                        it, ob_addr.size(), done_cyc, n, 2 * n + 18);
      end
      total++;
      if (err_at_done != exp_err) begin
        bad++; $display("FAIL rnd%0d_err got=%0d exp=%0d", it, err_at_done, exp_err);
      end
      for (int i = 0; i < n && i < ob_addr.size(); i++) begin
        total++;
        if (ob_addr[i] != (base + i) % 512 || ob_code[i] != exp_code[i] ||
            ob_len[i] != exp_len[i] || ob_rcode[i] != exp_rcode[i]) begin
          bad++; $display("FAIL rnd%0d_sym%0d got a=%0d c=%0d l=%0d r=%0d exp a=%0d c=%0d l=%0d r=%0d",
                          it, i, ob_addr[i], ob_code[i], ob_len[i], ob_rcode[i],
                          (base + i) % 512, exp_code[i], exp_len[i], exp_rcode[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) lenmem[i] = 5'($urandom_range(0, 15));
    model(12);
    run_job(12, 40, 1);
    total++;
    if (ob_addr.size() != 12 || done_cyc != 42 || done_cnt != 1) begin
      bad++; $display("FAIL b2b_job got writes=%0d done=%0d cnt=%0d exp 12,42,1",
                      ob_addr.size(), done_cyc, done_cnt);
    end
    for (int i = 0; i < 12 && i < ob_addr.size(); i++) begin
      total++;
      if (ob_addr[i] != 40 + i || ob_code[i] != exp_code[i] || ob_len[i] != exp_len[i]) begin
        bad++; $display("FAIL b2b_sym%0d got a=%0d c=%0d l=%0d exp a=%0d c=%0d l=%0d",
                        i, ob_addr[i], ob_code[i], ob_len[i], 40 + i, exp_code[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_clamp();
    int miss;
    miss = 0;
    for (int i = 0; i < 300; i++) lenmem[i] = 5'($urandom_range(0, 15));
    model(288);
    run_job(300, 3, 0);
    total++;
    if (ob_addr.size() != 288 || done_cyc != 594) begin
      bad++; $display("FAIL clamp_job got writes=%0d done=%0d exp 288,594", ob_addr.size(), done_cyc);
    end
    for (int i = 0; i < 288 && i < ob_addr.size(); i++)
      if (ob_addr[i] != i + 3 || ob_code[i] != exp_code[i] || ob_len[i] != exp_len[i]) miss++;
    total++;
    if (miss != 0) begin
      bad++; $display("FAIL clamp_entries got %0d wrong entries exp 0", miss);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    load_example();
    @(negedge clk);
    start = 1'b1; sym_num = AW'(10); base_addr = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({wen, done, busy, err} !== 4'b0000 || raddr !== '0 || waddr !== '0 ||
        code !== '0 || tlen !== '0) begin
      bad++; $display("FAIL midrst_outputs got ctl=%b raddr=%0d waddr=%0d code=%0d len=%0d exp 0",
                      {wen, done, busy, err}, raddr, waddr, code, tlen);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (wen || done || busy) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL midrst_stray got=%0d exp=0", stray);
    end
    run_job(10, 0, 0);
    total++;
    if (done_cyc != 38 || ob_addr.size() != 10) begin
      bad++; $display("FAIL midrst_rerun got done=%0d writes=%0d exp 38,10", done_cyc, ob_addr.size());
    end
    if (ob_code.size() == 10) begin
      total++;
      if (ob_code[3] != 14 || ob_code[9] != 6) begin
        bad++; $display("FAIL midrst_codes got=%0d,%0d exp=14,6", ob_code[3], ob_code[9]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) lenmem[i] = 5'd0;
    #2;
    test_reset();
    test_example();
    test_oversub();
    test_empty();
    test_wrap();
    test_random();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huff_table_builder.md
HUFF_TABLE_BUILDER -- requirements
Module: huff_table_builder

Interface
REQ-001 Parameter: MAX_SYMS, default 288; maximum symbol count per job.
REQ-002 Parameter: MAX_LEN, default 15; maximum code length in bits.
REQ-003 Parameter: ADDR_W, default 9; width of length-buffer and table addresses.
REQ-004 Parameter: CODE_REV, default 0; 1 = emit codes bit-reversed within tbl_len bits (LSB-first decoder).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle job request; sampled only in IDLE.
REQ-008 sym_num  input  ADDR_W  symbols in job (0..MAX_SYMS); captured on accepted start.
REQ-009 base_addr  input  ADDR_W  table write offset; captured on accepted start.
REQ-010 len_raddr  output  ADDR_W  code-length buffer read address.
REQ-011 len_rdata  input  5  code length; valid exactly 1 cycle after len_raddr is driven.
REQ-012 tbl_wen  output  1  table write strobe.
REQ-013 tbl_waddr  output  ADDR_W  base_addr + symbol index, modulo 2^ADDR_W.
REQ-014 tbl_code  output  MAX_LEN  canonical code, right-aligned.
REQ-015 tbl_len  output  4  code length; 0 = unused symbol.
REQ-016 busy  output  1  high from accepted start through the done cycle.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  sticky error flag, cleared on next accepted start.

Function
REQ-019 FSM states SHALL be IDLE, CNT, CODE, ASSIGN, DONE; start in IDLE moves to CNT; DONE returns to IDLE unconditionally.
REQ-020 On entering CNT, bl_count[1..MAX_LEN] SHALL be cleared; CNT issues len_raddr 0..N-1, one per cycle, and lasts N+1 cycles so the last returned length is counted.
REQ-021 Length 0 SHALL NOT be counted; bl_count entries are ADDR_W+1 bits wide.
REQ-022 CODE SHALL last exactly MAX_LEN cycles, computing next_code[L] = (next_code[L-1] + bl_count[L-1]) << 1 for L = 1..MAX_LEN, with next_code[0] = 0 and bl_count[0] = 0, truncated to MAX_LEN bits.
REQ-023 ASSIGN SHALL re-read addresses 0..N-1 and last N+1 cycles; one tbl_wen per symbol, in index order, one cycle after its read.
REQ-024 For L != 0, write code = next_code[L] (bit-reversed over L bits if CODE_REV = 1), then post-increment next_code[L]; for L = 0, write code 0, len 0.
REQ-025 done SHALL pulse in cycle 2N + MAX_LEN + 3, counting the start cycle as 0.
REQ-026 sym_num = 0: no tbl_wen; CNT and ASSIGN each last 1 cycle; done in cycle MAX_LEN + 3.
REQ-027 start while busy SHALL be ignored, with no effect on the running job.
REQ-028 sym_num > MAX_SYMS SHALL be clamped to MAX_SYMS.
REQ-029 tbl_wen, done and len_raddr SHALL be 0 in IDLE.

Reset
REQ-030 rst_n low SHALL force IDLE asynchronously and zero every output, bl_count, next_code and all captured registers.
REQ-031 Reset mid-job SHALL abort the job; no done and no further tbl_wen after release.

Configuration
REQ-032 With HUFF_TBL_CHECK_EN defined, err SHALL be set for either of these conditions:
- any len_rdata > MAX_LEN, detected in CNT;
- an oversubscribed code set, detected in CODE with left = 1, then per L: left = 2*left - bl_count[L], error if left < 0.
REQ-033 Incomplete code sets SHALL NOT set err; an erroneous job still runs to done.
REQ-034 Without HUFF_TBL_CHECK_EN, err SHALL be tied 0 and no check logic is built.

Verification
REQ-035 Lengths 3,3,3,4,3,2,0,4,0,3 with N = 10, base 0, CODE_REV = 0 -> codes 2,3,4,14,5,0,0,15,0,6 with lens 3,3,3,4,3,2,0,4,0,3; done at cycle 38; err 0.
REQ-036 Same lengths with CODE_REV = 1 -> symbol 3 code 7, symbol 5 code 0, symbol 9 code 3.
REQ-037 Lengths 1,1,1 with check enabled -> err = 1, 3 writes, done still pulses; without the macro, err stays 0.
REQ-038 N = 0 -> no tbl_wen; done at cycle 18 (MAX_LEN = 15).
REQ-039 base_addr = 510, N = 4 -> tbl_waddr sequence 510, 511, 0, 1.
REQ-040 rst_n low at cycle 12 of an N = 10 job -> all outputs 0; a new start after release completes correctly with done at cycle 38.
